// File: rtl/reg_pkg.sv
// reg_pkg: request/response types shared between register initiators and
// targets on the always-on peripheral port.
//   reg_req_t : valid, write, addr[31:0], wdata[31:0], wstrb[3:0]
//   reg_rsp_t : ready, error, rdata[31:0]
package reg_pkg;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_req_t;

    typedef struct packed {
        logic        ready;
        logic        error;
        logic [31:0] rdata;
    } reg_rsp_t;

endpackage

// File: rtl/reg_cmd_target.sv
// reg_cmd_target: register-port responder that buffers command-word writes in
// a FIFO, streams them to a downstream engine over valid/ready, and latches a
// completion pulse into a sticky flag that can drive an interrupt.
//
// Register map (decoded on addr[3:2]):
//   0x0 CMD     : write pushes wdata (wstrb ignored), reads 0
//   0x4 STATUS  : [0] empty, [1] full, [8+CNT_W-1:8] count, [16] done_sticky (W1C)
//   0x8 SCRATCH : 32-bit R/W, byte enables honoured
//   0xC IRQ_EN  : bit 0 R/W
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   reg_req_i    register request
//   reg_rsp_o    register response (ready, error = 0, rdata)
//   cmd_valid_o  FIFO head valid
//   cmd_data_o   FIFO head word (0 when empty)
//   cmd_ready_i  consumer accepts head
//   done_i       single-cycle completion pulse from consumer
//   irq_o        level interrupt = done_sticky & irq_en
module reg_cmd_target #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  reg_pkg::reg_req_t reg_req_i,
    output reg_pkg::reg_rsp_t reg_rsp_o,
    output logic              cmd_valid_o,
    output logic [31:0]       cmd_data_o,
    input  logic              cmd_ready_i,
    input  logic              done_i,
    output logic              irq_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ADDR_CMD     = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_SCRATCH = 2'd2;
    localparam logic [1:0] ADDR_IRQ_EN  = 2'd3;

    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_scratch;
    logic             r_irq_en;
    logic             r_done_sticky;

    logic [1:0]  w_sel;
    logic        w_empty;
    logic        w_full;
    logic        w_cmd_wr;
    logic        w_ready;
    logic        w_xfer_wr;
    logic        w_push;
    logic        w_pop;
    logic        w_sticky_clr;
    logic [31:0] w_status;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_sel    = reg_req_i.addr[3:2];
    assign w_unused = ^{reg_req_i.addr[31:4], reg_req_i.addr[1:0]};

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));

    // Only a CMD write into a full FIFO stalls; fullness is judged at the
    // start of the cycle, so a same-cycle pop does not release the stall.
    assign w_cmd_wr  = reg_req_i.valid && reg_req_i.write && (w_sel == ADDR_CMD);
    assign w_ready   = !(w_cmd_wr && w_full);
    assign w_xfer_wr = reg_req_i.valid && reg_req_i.write && w_ready;

    assign w_push = w_cmd_wr && w_ready;
    assign w_pop  = !w_empty && cmd_ready_i;

    assign w_sticky_clr = w_xfer_wr && (w_sel == ADDR_STATUS)
                          && reg_req_i.wdata[16] && reg_req_i.wstrb[2];

    always_comb begin
        w_status              = '0;
        w_status[0]           = w_empty;
        w_status[1]           = w_full;
        w_status[8 +: CNT_W]  = r_count;
        w_status[16]          = r_done_sticky;
    end

    always_comb begin
        w_rdata = '0;
        if (reg_req_i.valid && !reg_req_i.write) begin
            unique case (w_sel)
                ADDR_CMD:     w_rdata = '0;
                ADDR_STATUS:  w_rdata = w_status;
                ADDR_SCRATCH: w_rdata = r_scratch;
                ADDR_IRQ_EN:  w_rdata = {31'd0, r_irq_en};
                default:      w_rdata = '0;
            endcase
        end
    end

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = w_ready;
        reg_rsp_o.error = 1'b0;
        reg_rsp_o.rdata = w_rdata;
    end

    // Storage needs no reset: the head is masked to 0 while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= reg_req_i.wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_scratch     <= '0;
            r_irq_en      <= 1'b0;
            r_done_sticky <= 1'b0;
        end else begin
            if (w_xfer_wr && (w_sel == ADDR_SCRATCH)) begin
                for (int b = 0; b < 4; b++) begin
                    if (reg_req_i.wstrb[b]) begin
                        r_scratch[8*b +: 8] <= reg_req_i.wdata[8*b +: 8];
                    end
                end
            end
            if (w_xfer_wr && (w_sel == ADDR_IRQ_EN) && reg_req_i.wstrb[0]) begin
                r_irq_en <= reg_req_i.wdata[0];
            end
            // A completion pulse in the same cycle as a clear must not be lost.
            if (done_i) begin
                r_done_sticky <= 1'b1;
            end else if (w_sticky_clr) begin
                r_done_sticky <= 1'b0;
            end
        end
    end

    assign cmd_valid_o = !w_empty;
    assign cmd_data_o  = w_empty ? 32'd0 : r_mem[r_rptr];
    assign irq_o       = r_done_sticky & r_irq_en;

endmodule

// File: tb/tb_reg_cmd_target.sv
// Bench for reg_cmd_target: directed stimulus pushes expected read data and
// expected command words into queues; a negedge monitor pops and compares
// whenever a read completes or the consumer takes a word.
module tb_reg_cmd_target;

    logic              clk;
    logic              rst_n;
    reg_pkg::reg_req_t req;
    reg_pkg::reg_rsp_t rsp;
    logic              cmd_valid;
    logic [31:0]       cmd_data;
    logic              cmd_ready;
    logic              done;
    logic              irq;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] read_q[$];
    logic [31:0] cmd_q[$];

    reg_cmd_target #(.FIFO_DEPTH(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .reg_req_i   (req),
        .reg_rsp_o   (rsp),
        .cmd_valid_o (cmd_valid),
        .cmd_data_o  (cmd_data),
        .cmd_ready_i (cmd_ready),
        .done_i      (done),
        .irq_o       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares completed reads and consumed command words.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req.valid && !req.write && rsp.ready) begin
                if (read_q.size() == 0) begin
                    check("unexpected_read", 32'd1, 32'd0);
                end else begin
                    check("read_data", rsp.rdata, read_q.pop_front());
                end
                check("error_bit", {31'd0, rsp.error}, 32'd0);
            end
            if (cmd_valid && cmd_ready) begin
                if (cmd_q.size() == 0) begin
                    check("unexpected_cmd", cmd_data, 32'hDEAD_BEEF);
                end else begin
                    check("cmd_word", cmd_data, cmd_q.pop_front());
                end
            end
        end
    end

    // All bus tasks start at posedge+1 and return at a later posedge+1.
    task automatic bus_op(input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb);
        int k;
        req.valid = 1'b1;
        req.write = wr;
        req.addr  = addr;
        req.wdata = data;
        req.wstrb = strb;
        k = 0;
        @(negedge clk);
        while (!rsp.ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k == 50) check("bus_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        req.valid = 1'b0;
        req.write = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        bus_op(1'b1, addr, data, strb);
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp);
        read_q.push_back(exp);
        bus_op(1'b0, addr, 32'd0, 4'd0);
    endtask

    task automatic cmd_push(input logic [31:0] data);
        cmd_q.push_back(data);
        bus_write(32'h0, data, 4'hF);
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (cmd_q.size() != 0 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, cmd_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req       = '0;
        cmd_ready = 1'b0;
        done      = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_ready", {31'd0, rsp.ready}, 32'd1);
        check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check("rst_cmd_data", cmd_data, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rdata", rsp.rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state via register reads.
        bus_read(32'h0, 32'h0);
        bus_read(32'h4, 32'h0000_0001);
        bus_read(32'h8, 32'h0);
        bus_read(32'hC, 32'h0);
        check("idle_irq", {31'd0, irq}, 32'd0);
        check("idle_ready", {31'd0, rsp.ready}, 32'd1);

        // Fill the FIFO, then stall a fifth write behind a single pop.
        for (int i = 0; i < 4; i++) cmd_push(32'hA0 + i);
        bus_read(32'h4, 32'h0000_0402);
        cmd_q.push_back(32'hA4);
        req.valid = 1'b1;
        req.write = 1'b1;
        req.addr  = 32'h0;
        req.wdata = 32'hA4;
        req.wstrb = 4'hF;
        cmd_ready = 1'b1;
        #2;
        check("full_stall_ready", {31'd0, rsp.ready}, 32'd0);
        @(posedge clk);
        #1;
        cmd_ready = 1'b0;
        #1;
        check("stall_release_ready", {31'd0, rsp.ready}, 32'd1);
        check("head_after_pop", cmd_data, 32'hA1);
        @(posedge clk);
        #1;
        req.valid = 1'b0;
        req.write = 1'b0;
        bus_read(32'h4, 32'h0000_0402);
        cmd_ready = 1'b1;
        wait_drain("drain_fill");
        @(posedge clk);
        #1;
        check("empty_after_drain", {31'd0, cmd_valid}, 32'd0);

        // Streaming: push every cycle while the consumer is always ready.
        for (int i = 1; i <= 10; i++) begin
            cmd_q.push_back(i);
            req.valid = 1'b1;
            req.write = 1'b1;
            req.addr  = 32'h0;
            req.wdata = i;
            req.wstrb = 4'hF;
            #2;
            check("stream_ready", {31'd0, rsp.ready}, 32'd1);
            check("stream_valid", {31'd0, cmd_valid}, (i == 1) ? 32'd0 : 32'd1);
            @(posedge clk);
            #1;
        end
        req.valid = 1'b0;
        req.write = 1'b0;
        wait_drain("drain_stream");
        bus_read(32'h4, 32'h0000_0001);
        cmd_ready = 1'b0;

        // Scratch byte enables.
        bus_write(32'h8, 32'hFFFF_FFFF, 4'hF);
        bus_write(32'h8, 32'h1234_5678, 4'b0101);
        bus_read(32'h8, 32'hFF34_FF78);
        bus_write(32'hC, 32'hFFFF_FFFF, 4'hF);
        bus_read(32'hC, 32'h0000_0001);

        // done pulse, set-wins-over-clear, then clear alone.
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        check("irq_after_done", {31'd0, irq}, 32'd1);
        bus_read(32'h4, 32'h0001_0001);
        done = 1'b1;
        bus_write(32'h4, 32'h0001_0000, 4'b0100);
        done = 1'b0;
        check("irq_set_wins", {31'd0, irq}, 32'd1);
        bus_read(32'h4, 32'h0001_0001);
        bus_write(32'h4, 32'h0001_0000, 4'b0011);
        check("clear_needs_strb", {31'd0, irq}, 32'd1);
        bus_write(32'h4, 32'h0001_0000, 4'b0100);
        check("irq_after_clear", {31'd0, irq}, 32'd0);
        bus_read(32'h4, 32'h0000_0001);

        // Reset mid-stream discards queued words immediately.
        bus_write(32'h0, 32'hB0, 4'hF);
        bus_write(32'h0, 32'hB1, 4'hF);
        bus_write(32'h0, 32'hB2, 4'hF);
        check("pre_reset_valid", {31'd0, cmd_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_valid_now", {31'd0, cmd_valid}, 32'd0);
        check("reset_data_now", cmd_data, 32'd0);
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus_read(32'h4, 32'h0000_0001);
        bus_read(32'h8, 32'h0);
        bus_read(32'hC, 32'h0);

        repeat (2) @(posedge clk);
        check("read_q_empty", read_q.size(), 32'd0);
        check("cmd_q_empty", cmd_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_cmd_target.md
# reg_cmd_target

Register-interface responder for the external always-on peripheral port, the target end of the `reg_req_t`/`reg_rsp_t` requests issued by SPC-style initiators. Command-word writes are buffered in a FIFO and streamed to a downstream engine over valid/ready. A completion pulse from that engine sets a sticky flag that can raise an interrupt line toward the external interrupt vector. Status, scratch and interrupt-enable registers are readable over the same port.

## Interface
- `FIFO_DEPTH`, default 4: command FIFO entries; power of two, ≥2.
- `CNT_W`, default `$clog2(FIFO_DEPTH)+1`: occupancy counter width (derived; do not override).
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. One clock; reset is asynchronous and active-low.
- `reg_req_i`  in  `reg_pkg::reg_req_t`  request: valid, write, addr[31:0], wdata[31:0], wstrb[3:0].
- `reg_rsp_o`  out  `reg_pkg::reg_rsp_t`  response: ready, error, rdata[31:0].
- `cmd_valid_o`  out  1  FIFO head valid.
- `cmd_data_o`  out  32  FIFO head word.
- `cmd_ready_i`  in  1  consumer accepts head.
- `done_i`  in  1  single-cycle completion pulse from consumer.
- `irq_o`  out  1  level interrupt.

## Operation
- Decode on `addr[3:2]`; `addr[31:4]` and `addr[1:0]` ignored.
  - 0x0 CMD: write pushes full `wdata` and ignores `wstrb`; read returns 0.
  - 0x4 STATUS (RO except bit 16): [0] empty, [1] full, [8+CNT_W-1:8] count, [16] done_sticky (W1C), other bits 0.
  - 0x8 SCRATCH: R/W 32-bit, byte-wise per `wstrb`.
  - 0xC IRQ_EN: bit 0 R/W (`wstrb[0]`), other bits read 0.
- Address decode has no error response; all four offsets are mapped. `error` is always 0.
- A transfer completes in the cycle with `valid && ready`. Side effects apply only at completion.
- `ready` = 0 only for a CMD write while the FIFO is full at the start of the cycle. Otherwise `ready` = 1 whenever `valid` = 1. `ready` = 1 when idle.
- `rdata` is combinational from the register state at the start of the cycle. It returns 0 for writes and when `valid` = 0.
- FIFO: `cmd_valid_o` = !empty and `cmd_data_o` = head entry. A pop occurs on `cmd_valid_o && cmd_ready_i`. FIFO order is strict.
- Simultaneous push and pop on a non-full FIFO: count is unchanged and both take effect.
- Pop while a stalled push is pending on a full FIFO: the push is still refused that cycle and completes the next cycle.
- `done_sticky` is set by `done_i`. It is cleared by a STATUS write with `wdata[16]=1 && wstrb[2]=1`. If set and clear occur in the same cycle, set wins.
- `irq_o` = `done_sticky & irq_en`, driven from registers only, with no combinational path from inputs.
- Reset value of every output:
  - `reg_rsp_o.ready` = 1; `error` = 0; `rdata` = 0.
  - `cmd_valid_o` = 0; `cmd_data_o` = 0.
  - `irq_o` = 0.
- Reset value of internal state: FIFO empty; SCRATCH, IRQ_EN and `done_sticky` all 0.
- Reset asserted mid-operation discards FIFO contents and any stalled request immediately. It is asynchronous and takes no clock.

## Timing
- Write latency: the register update is visible on `rdata` and outputs the cycle after completion.
- CMD push: `cmd_valid_o` rises the cycle after the accepted write, so minimum request-to-consumer latency is 1 cycle.
- Pop: the next head appears the cycle after the pop. `cmd_valid_o` falls the cycle after the last pop.
- `done_i` to `irq_o`: 1 cycle when `irq_en` = 1. Clear to `irq_o` low: 1 cycle.
- Throughput: one register access per cycle. Sustained push plus pop runs at 1 word/cycle.
- Counter never wraps: count ∈ [0, FIFO_DEPTH]. Read/write pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally.

## Test plan
- Reset, then read all four offsets -> STATUS = 0x0000_0001; SCRATCH, IRQ_EN and CMD read 0; `irq_o` = 0; `ready` = 1.
- Push 0xA0, 0xA1, 0xA2, 0xA3 with `cmd_ready_i` = 0 -> STATUS = 0x0000_0402 (count 4, full). A fifth write 0xA4 sees `ready` = 0. Raise `cmd_ready_i` for one cycle -> 0xA0 pops, 0xA4 completes the following cycle, and the consumer then receives 0xA1..0xA4 in order.
- Hold `cmd_ready_i` = 1 and write CMD every cycle for 10 cycles (0x1..0xA) -> each word appears one cycle later, count stays ≤1, and `ready` is never low.
- Write SCRATCH 0xFFFF_FFFF then 0x1234_5678 with `wstrb` = 4'b0101 -> read 0xFF34_FF78.
- IRQ_EN = 1, pulse `done_i` -> `irq_o` = 1 next cycle and STATUS[16] = 1. Write STATUS 0x0001_0000 in the same cycle as another `done_i` -> bit stays 1. Clear alone -> `irq_o` = 0 next cycle.
- Push 3 words, then assert `rst_ni` = 0 for one cycle mid-stream -> `cmd_valid_o` = 0 immediately and STATUS = 0x0000_0001 after release.
